// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Hits answer in one cycle; misses issue a single word fetch to the arbiter and fill the line.
module icache_direct #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INST_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_flush_in,
  input  logic                  fetch_req_in,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_in,
  output logic                  fetch_rdy_out,
  output logic                  fetch_valid_out,
  output logic [INST_WIDTH-1:0] fetch_inst_out,
  output logic                  mem_en_out,
  output logic [ADDR_WIDTH-1:0] mem_pc_out,
  input  logic                  mem_en_in,
  input  logic [INST_WIDTH-1:0] mem_inst_in
);

  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int unsigned NUM_LINES = 1 << INDEX_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  state_e                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]    tag_q  [NUM_LINES];
  logic [INST_WIDTH-1:0]   data_q [NUM_LINES];
  logic                    fetch_valid_q;
  logic [INST_WIDTH-1:0]   fetch_inst_q;
  logic [ADDR_WIDTH-1:0]   mem_pc_q;

  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  fill_idx;
  logic [TAG_WIDTH-1:0]    fill_tag;
  logic                    hit_c;
  logic                    fill_c;
  logic                    unused_pc_lsb;

  assign req_idx  = fetch_pc_in[INDEX_WIDTH+1:2];
  assign req_tag  = fetch_pc_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign fill_idx = mem_pc_q[INDEX_WIDTH+1:2];
  assign fill_tag = mem_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit_c    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_c   = (state_q == S_MISS) && mem_en_in && !rob_flush_in;

  // Word-aligned fetch: byte offset bits carry no information.
  assign unused_pc_lsb = ^fetch_pc_in[1:0];

  // Request drops in the done cycle so the arbiter never relaunches it.
  assign mem_en_out      = (state_q == S_MISS) && !mem_en_in && !rob_flush_in;
  assign fetch_rdy_out   = (state_q == S_IDLE);
  assign fetch_valid_out = fetch_valid_q;
  assign fetch_inst_out  = fetch_inst_q;
  assign mem_pc_out      = mem_pc_q;

  // Control FSM, valid bits and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= '0;
      mem_pc_q      <= '0;
    end else if (rdy_in) begin
      fetch_valid_q <= 1'b0;
      if (rob_flush_in) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fetch_req_in) begin
              if (hit_c) begin
                fetch_valid_q <= 1'b1;
                fetch_inst_q  <= data_q[req_idx];
              end else begin
                mem_pc_q <= {fetch_pc_in[ADDR_WIDTH-1:2], 2'b00};
                state_q  <= S_MISS;
              end
            end
          end
          S_MISS: begin
            if (mem_en_in) begin
              valid_q[fill_idx] <= 1'b1;
              fetch_valid_q     <= 1'b1;
              fetch_inst_q      <= mem_inst_in;
              state_q           <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every lookup.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_c) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst_in;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: fills, hits, eviction, flush, stall and reset-mid-miss.
module tb_icache_direct;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_flush_in;
  logic        fetch_req_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_rdy_out;
  logic        fetch_valid_out;
  logic [31:0] fetch_inst_out;
  logic        mem_en_out;
  logic [31:0] mem_pc_out;
  logic        mem_en_in;
  logic [31:0] mem_inst_in;

  int total = 0;
  int bad   = 0;

  icache_direct #(.INDEX_WIDTH(8), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .rob_flush_in    (rob_flush_in),
    .fetch_req_in    (fetch_req_in),
    .fetch_pc_in     (fetch_pc_in),
    .fetch_rdy_out   (fetch_rdy_out),
    .fetch_valid_out (fetch_valid_out),
    .fetch_inst_out  (fetch_inst_out),
    .mem_en_out      (mem_en_out),
    .mem_pc_out      (mem_pc_out),
    .mem_en_in       (mem_en_in),
    .mem_inst_in     (mem_inst_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, leaving the bench just after the falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic request(input logic [31:0] pc);
    fetch_req_in = 1'b1;
    fetch_pc_in  = pc;
    @(posedge clk_in);
    @(negedge clk_in);
    fetch_req_in = 1'b0;
    #1;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] pc, input logic [31:0] data);
    request(pc);
    chk({tag, "_valid"}, 32'(fetch_valid_out), 32'd1);
    chk({tag, "_inst"}, fetch_inst_out, data);
    chk({tag, "_memen"}, 32'(mem_en_out), 32'd0);
  endtask

  task automatic expect_miss(input string tag, input logic [31:0] pc);
    request(pc);
    chk({tag, "_novalid"}, 32'(fetch_valid_out), 32'd0);
    chk({tag, "_notrdy"}, 32'(fetch_rdy_out), 32'd0);
    chk({tag, "_memen"}, 32'(mem_en_out), 32'd1);
    chk({tag, "_mempc"}, mem_pc_out, {pc[31:2], 2'b00});
  endtask

  task automatic complete(input string tag, input logic [31:0] data);
    mem_en_in   = 1'b1;
    mem_inst_in = data;
    #1;
    chk({tag, "_done_memen"}, 32'(mem_en_out), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    mem_en_in = 1'b0;
    #1;
    chk({tag, "_fill_valid"}, 32'(fetch_valid_out), 32'd1);
    chk({tag, "_fill_inst"}, fetch_inst_out, data);
    chk({tag, "_fill_rdy"}, 32'(fetch_rdy_out), 32'd1);
    step();
    chk({tag, "_pulse_end"}, 32'(fetch_valid_out), 32'd0);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_flush_in = 1'b0;
    fetch_req_in = 1'b0; fetch_pc_in = '0;
    mem_en_in = 1'b0; mem_inst_in = '0;
    @(negedge clk_in);
    step();
    step();
    rst_in = 1'b1;
    #1;
    chk("rst_valid", 32'(fetch_valid_out), 32'd0);
    chk("rst_inst", fetch_inst_out, 32'd0);
    chk("rst_mempc", mem_pc_out, 32'd0);
    chk("rst_rdy", 32'(fetch_rdy_out), 32'd1);
    chk("rst_memen", 32'(mem_en_out), 32'd0);

    // Cold miss on line 0, two-cycle arbiter wait.
    expect_miss("m0", 32'h0000_0000);
    step();
    chk("m0_wait_memen", 32'(mem_en_out), 32'd1);
    complete("m0", 32'h0000_0013);

    expect_hit("h0", 32'h0000_0000, 32'h0000_0013);
    expect_hit("h0_lsb", 32'h0000_0003, 32'h0000_0013);

    // Four back-to-back hits.
    fetch_req_in = 1'b1;
    fetch_pc_in  = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      chk("b2b_valid", 32'(fetch_valid_out), 32'd1);
      chk("b2b_inst", fetch_inst_out, 32'h0000_0013);
      chk("b2b_memen", 32'(mem_en_out), 32'd0);
    end
    fetch_req_in = 1'b0;
    step();
    chk("b2b_end", 32'(fetch_valid_out), 32'd0);

    // Eviction: 0x004 and 0x404 share index 1.
    expect_miss("m4", 32'h0000_0004);
    complete("m4", 32'hAAAA_AAAA);
    expect_hit("h4", 32'h0000_0004, 32'hAAAA_AAAA);
    expect_miss("m404", 32'h0000_0404);
    complete("m404", 32'hBBBB_BBBB);
    expect_hit("h404", 32'h0000_0404, 32'hBBBB_BBBB);
    expect_miss("evict4", 32'h0000_0004);
    complete("evict4", 32'hAAAA_AAAA);

    // Unaligned miss address is word-aligned on the arbiter side.
    expect_miss("m502", 32'h0000_0502);
    complete("m502", 32'h5555_0502);

    // Flush three cycles into a miss.
    expect_miss("m100", 32'h0000_0100);
    step();
    step();
    rob_flush_in = 1'b1;
    #1;
    chk("fl100_memen", 32'(mem_en_out), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    rob_flush_in = 1'b0;
    #1;
    chk("fl100_novalid", 32'(fetch_valid_out), 32'd0);
    chk("fl100_rdy", 32'(fetch_rdy_out), 32'd1);
    chk("fl100_memen_after", 32'(mem_en_out), 32'd0);
    expect_miss("re100", 32'h0000_0100);
    complete("re100", 32'h1111_1111);

    // Flush coincident with the done pulse discards the fill.
    expect_miss("m200", 32'h0000_0200);
    step();
    mem_en_in    = 1'b1;
    mem_inst_in  = 32'hDEAD_BEEF;
    rob_flush_in = 1'b1;
    #1;
    chk("fl200_memen", 32'(mem_en_out), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    mem_en_in    = 1'b0;
    rob_flush_in = 1'b0;
    #1;
    chk("fl200_novalid", 32'(fetch_valid_out), 32'd0);
    chk("fl200_rdy", 32'(fetch_rdy_out), 32'd1);
    expect_miss("re200", 32'h0000_0200);
    complete("re200", 32'h2222_2222);
    expect_hit("h0_after_flush", 32'h0000_0000, 32'h0000_0013);

    // Flush coincident with a would-be hit suppresses the response.
    fetch_req_in = 1'b1;
    fetch_pc_in  = 32'h0000_0000;
    rob_flush_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    fetch_req_in = 1'b0;
    rob_flush_in = 1'b0;
    #1;
    chk("flhit_novalid", 32'(fetch_valid_out), 32'd0);

    // Five-cycle global stall during a miss.
    expect_miss("m300", 32'h0000_0300);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_memen", 32'(mem_en_out), 32'd1);
      chk("stall_mempc", mem_pc_out, 32'h0000_0300);
      chk("stall_rdy", 32'(fetch_rdy_out), 32'd0);
    end
    rdy_in = 1'b1;
    complete("m300", 32'h3333_3333);
    expect_hit("h300", 32'h0000_0300, 32'h3333_3333);

    // Reset mid-miss clears the request and every valid bit.
    expect_miss("m600", 32'h0000_0600);
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    #1;
    chk("rstmid_rdy", 32'(fetch_rdy_out), 32'd1);
    chk("rstmid_memen", 32'(mem_en_out), 32'd0);
    chk("rstmid_mempc", mem_pc_out, 32'd0);
    expect_miss("cold0", 32'h0000_0000);
    complete("cold0", 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the fetch unit (upstream) and the RAM read/write arbiter (downstream, IF port).
- Services fetch requests: a hit returns in 1 cycle; a miss issues one word fetch to the arbiter and fills the line.
- Contents survive an ROB flush. Any in-flight miss is abandoned.

Parameters:
- INDEX_WIDTH, 8: line index bits (256 lines, one 32-bit instruction per line).
- ADDR_WIDTH, 32: PC width.
- INST_WIDTH, 32: instruction width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset. Synchronous, active-low: rst_in==0 at a posedge resets the block.
- rdy_in  in  1  global ready. When 0, all state holds.
- rob_flush_in  in  1  pipeline flush.
- fetch_req_in  in  1  fetch request. Sampled only when fetch_rdy_out=1.
- fetch_pc_in  in  ADDR_WIDTH  request PC. Bits [1:0] are ignored.
- fetch_rdy_out  out  1  cache can accept a request (state IDLE).
- fetch_valid_out  out  1  one-cycle pulse: fetch_inst_out is valid.
- fetch_inst_out  out  INST_WIDTH  returned instruction.
- mem_en_out  out  1  miss request to the arbiter IF port.
- mem_pc_out  out  ADDR_WIDTH  miss word address, low 2 bits forced to 0.
- mem_en_in  in  1  arbiter done pulse.
- mem_inst_in  in  INST_WIDTH  fetched word, valid when mem_en_in=1.

Behaviour:
- Address split: index = pc[INDEX_WIDTH+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].
- Storage per line: valid bit, tag, data. On reset all valid bits are cleared; tag/data contents are don't-care.
- Reset values: fetch_valid_out=0, fetch_inst_out=0, mem_pc_out=0, state=IDLE.
- State machine:
  - IDLE -> IDLE on a hit.
  - IDLE -> MISS on a miss.
  - MISS -> IDLE when mem_en_in=1 or rob_flush_in=1.
- IDLE, fetch_req_in=1 at posedge N:
  - Hit (valid && tag match): fetch_inst_out=data and fetch_valid_out=1 during cycle N+1; state stays IDLE. Back-to-back hits every cycle are supported.
  - Miss: latch the PC. mem_pc_out={pc[ADDR_WIDTH-1:2],2'b00} is registered and held stable for the whole MISS state; state -> MISS.
- mem_en_out is combinational: (state==MISS) && !mem_en_in && !rob_flush_in.
  - It must drop in the same cycle the done pulse is visible. The arbiter re-arbitrates at the end of that cycle, and a held request would launch a duplicate access.
- MISS, mem_en_in=1 at posedge M:
  - Write valid=1, tag and data=mem_inst_in into the line, overwriting any prior occupant.
  - fetch_inst_out=mem_inst_in and fetch_valid_out=1 during M+1.
  - state -> IDLE. fetch_rdy_out=1 from M+1; a new request may be sampled at the posedge ending M+1.
- Miss latency = arbiter latency + 1 cycle to the response.
- fetch_req_in while state != IDLE is ignored; the requester must hold or reissue.
- rob_flush_in=1 at a posedge (rdy_in=1):
  - state -> IDLE, fetch_valid_out=0 next cycle.
  - A coincident mem_en_in is discarded: no line write, no response.
  - A coincident fetch_req_in is ignored, including hits.
  - Valid array is unchanged.
- rdy_in=0:
  - No state, array or output-register change; mem_en_out and mem_pc_out hold.
  - mem_en_in arriving while rdy_in=0 is not captured. The arbiter is stalled by the same rdy_in, so this does not occur.
- Reset mid-miss: returns to IDLE and drops the request; the arbiter is reset by the same event.
- Precedence: reset > rdy_in=0 hold > flush > normal operation.

Test Plan:
- Reset (rst_in=0 for 2 cycles), then request PC 0x0000_0000 -> miss; mem_en_out=1, mem_pc_out=0x0. Arbiter returns 0x0000_0013 -> fetch_valid_out=1 with inst 0x0000_0013 one cycle after mem_en_in; mem_en_out=0 during the done cycle.
- Re-request 0x0000_0000 -> fetch_valid_out=1 next cycle with 0x0000_0013; mem_en_out never asserted. 4 consecutive hits -> 4 consecutive valid pulses.
- Fill 0x0000_0004 (data 0xAAAA_AAAA), then request 0x0000_0404 (same index 1, different tag) -> miss, mem_pc_out=0x404, fill 0xBBBB_BBBB. Re-request 0x004 -> miss again (eviction confirmed).
- Miss on 0x0000_0100, rob_flush_in pulsed 3 cycles in -> mem_en_out=0 that cycle, no fetch_valid_out. A later request to 0x100 misses again.
- Flush coincident with mem_en_in on a miss to 0x200 -> no response; a subsequent request to 0x200 is a miss; line 0x000 is still a hit.
- rdy_in=0 for 5 cycles during MISS -> mem_pc_out and mem_en_out held, state unchanged. After rdy_in=1 the fill completes normally.
